// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time,
// and hands {pc, pc_plus4, instr} to decode through a valid/ready register.
//
//   state | meaning
//   REQ   | request presented at pc, waiting for imem_req_ready
//   WAIT  | request accepted, waiting for its response
//   DROP  | stale request outstanding, its response will be discarded
//   HOLD  | bundle presented to decode, waiting for id_ready
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_add_a,
  output logic [31:0] pc_add_b,
  input  logic [31:0] pc_add_sum,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr
);

  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] tgt;
  logic        capture;

  assign tgt            = redirect_target & ~32'd3;
  assign pc_add_a       = pc;
  assign pc_add_b       = 32'd4;
  assign imem_addr      = pc;
  assign imem_req_valid = (state == REQ) && rst;
  assign id_valid       = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_instr    <= 32'd0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (capture) begin
        id_pc       <= pc;
        id_pc_plus4 <= pc_add_sum;
        id_instr    <= imem_rsp_data;
      end
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    capture = 1'b0;
    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // a response colliding with a redirect belongs to the old path
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          pc_d    = pc_add_sum;
          state_d = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = tgt;
        if (imem_rsp_valid) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (id_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (state == REQ || state == HOLD)));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a scoreboard of expected decode bundles is
// filled as responses are returned and drained as bundles are presented.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc_add_a, pc_add_b, pc_add_sum;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc, id_pc_plus4, id_instr;

  logic [31:0] w_pc_add_a, w_pc_add_b, w_pc_add_sum;
  logic        w_req_valid;
  logic        w_req_ready = 1'b0;
  logic [31:0] w_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = 32'd0;
  logic        w_id_valid;
  logic        w_id_ready = 1'b0;
  logic [31:0] w_id_pc, w_id_pc_plus4, w_id_instr;

  // external PC adders
  assign pc_add_sum   = pc_add_a + pc_add_b;
  assign w_pc_add_sum = w_pc_add_a + w_pc_add_b;

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst(rst),
    .pc_add_a(pc_add_a), .pc_add_b(pc_add_b), .pc_add_sum(pc_add_sum),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .pc_add_a(w_pc_add_a), .pc_add_b(w_pc_add_b), .pc_add_sum(w_pc_add_sum),
    .redirect_valid(1'b0), .redirect_target(32'd0),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .id_valid(w_id_valid), .id_ready(w_id_ready),
    .id_pc(w_id_pc), .id_pc_plus4(w_id_pc_plus4), .id_instr(w_id_instr)
  );

  int      errors = 0;
  int      checks = 0;
  bundle_t sb[$];
  bundle_t cur;

  function automatic logic [31:0] mkdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F81;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From REQ at address a: handshake, wait k cycles, return the word.
  task automatic issue(input logic [31:0] a, input int k);
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, a);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("req_drop_after_accept", {31'd0, imem_req_valid}, 32'd0);
    repeat (k - 1) step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mkdata(a);
    sb.push_back('{pc: a, pc4: a + 32'd4, instr: mkdata(a)});
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic present();
    chk("id_valid", {31'd0, id_valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=bundle expected=none");
    end else begin
      cur = sb.pop_front();
      chk("id_pc", id_pc, cur.pc);
      chk("id_pc_plus4", id_pc_plus4, cur.pc4);
      chk("id_instr", id_instr, cur.instr);
    end
  endtask

  initial begin
    // reset
    step();
    step();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_pc", pc_add_a, 32'h100);
    chk("rst_add_b", pc_add_b, 32'd4);
    rst = 1'b1;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // sequential fetch with zero-wait memory
    issue(32'h100, 1);
    present();
    step();
    id_ready = 1'b0;
    issue(32'h104, 1);
    present();

    // decode stall: bundle stable, no new request, pc already advanced
    repeat (5) begin
      step();
      chk("stall_id_valid", {31'd0, id_valid}, 32'd1);
      chk("stall_id_pc", id_pc, cur.pc);
      chk("stall_id_instr", id_instr, cur.instr);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_pc", pc_add_a, 32'h108);
    end
    id_ready = 1'b1;
    step();
    chk("release_addr", imem_addr, 32'h108);

    // redirect while waiting; late response discarded
    chk("w_req_valid", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h2000;
    step();
    redirect_valid = 1'b0;
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("drop_id_valid", {31'd0, id_valid}, 32'd0);
    issue(32'h2000, 1);
    present();
    step();

    // redirect in the same cycle as the request handshake
    chk("hs_addr", imem_addr, 32'h2004);
    imem_req_ready  = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h3003;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("hs_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0001;
    step();
    imem_rsp_valid = 1'b0;
    chk("hs_id_valid", {31'd0, id_valid}, 32'd0);
    issue(32'h3000, 2);
    present();
    step();

    // flush during HOLD: redirect wins over id_ready
    issue(32'h3004, 1);
    present();
    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    step();
    redirect_valid = 1'b0;
    chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h400);

    // redirect in REQ without handshake
    redirect_valid  = 1'b1;
    redirect_target = 32'h500;
    step();
    redirect_valid = 1'b0;
    chk("reqredir_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("reqredir_addr", imem_addr, 32'h500);

    // redirect and response collide in WAIT
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h600;
    imem_rsp_valid  = 1'b1;
    imem_rsp_data   = 32'hBAD0_0002;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("collide_id_valid", {31'd0, id_valid}, 32'd0);
    chk("collide_addr", imem_addr, 32'h600);
    issue(32'h600, 3);
    present();
    step();
    chk("sb_drained", sb.size(), 32'd0);

    // wrap-around from RESET_PC = 0xFFFF_FFFC
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b1;
    step();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = mkdata(32'hFFFF_FFFC);
    step();
    w_rsp_valid = 1'b0;
    chk("wrap_id_valid", {31'd0, w_id_valid}, 32'd1);
    chk("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_pc_plus4", w_id_pc_plus4, 32'd0);
    chk("wrap_id_instr", w_id_instr, mkdata(32'hFFFF_FFFC));
    w_id_ready = 1'b1;
    step();
    chk("wrap_addr1", w_addr, 32'd0);
    chk("wrap_req_valid", {31'd0, w_req_valid}, 32'd1);

    // reset while a fetch is outstanding
    chk("mid_addr", imem_addr, 32'h100);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    step();
    chk("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("mid_rst_pc", pc_add_a, 32'h100);
    rst = 1'b1;
    #1;
    chk("mid_req_valid", {31'd0, imem_req_valid}, 32'd1);
    issue(32'h100, 1);
    present();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch front end that owns the architectural program counter. It drives the PC into the 32-bit PC adder (operands PC and 4) and consumes the adder sum as the sequential next PC. It issues one outstanding instruction-memory request at a time and presents {pc, pc_plus4, instr} to decode through a valid/ready register. It handles branch/jump redirects and flushes at any point of an outstanding fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low
pc_add_a  output  32  PC adder operand a; always equals the pc register
pc_add_b  output  32  PC adder operand b; constant 32'd4
pc_add_sum  input  32  PC adder result (pc + 4)
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  new PC; bits [1:0] ignored and forced to 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  fetch address
imem_rsp_valid  input  1  instruction returned, single-cycle pulse
imem_rsp_data  input  32  instruction word
id_valid  output  1  decode-stage bundle valid
id_ready  input  1  decode accepts bundle
id_pc  output  32  PC of the presented instruction
id_pc_plus4  output  32  pc_add_sum captured with the instruction
id_instr  output  32  instruction word

Behaviour:
- Reset (rst==0 at a clock edge): pc<=RESET_PC, state<=REQ, id_valid<=0, id_pc/id_pc_plus4/id_instr<=0. imem_req_valid is 0 in any cycle where rst==0.
- States: REQ, WAIT, DROP, HOLD. Request and handshake outputs are decoded from state only (Moore): imem_req_valid=(state==REQ), imem_addr=pc, id_valid=(state==HOLD).
- REQ:
  - imem_req_ready=1 and no redirect -> WAIT.
  - No imem_req_ready and redirect -> pc<=target, stay REQ.
  - imem_req_ready=1 and redirect in the same cycle -> pc<=target, go to DROP, because the issued request is stale.
- WAIT:
  - imem_rsp_valid and no redirect -> id_instr<=rsp_data, id_pc<=pc, id_pc_plus4<=pc_add_sum, pc<=pc_add_sum, go to HOLD.
  - Redirect with no rsp -> pc<=target, go to DROP.
  - Redirect and rsp in the same cycle -> discard rsp, pc<=target, go to REQ.
- DROP:
  - Waits for the stale response. imem_rsp_valid -> discard, go to REQ.
  - Redirect in DROP -> pc<=target, stay DROP, unless rsp arrives in the same cycle, in which case go to REQ with the new target.
- HOLD:
  - id_ready=1 -> go to REQ.
  - Redirect has priority over id_ready: pc<=target, go to REQ, bundle dropped (flush). id_valid is low the next cycle.
- pc is updated only at the points listed above. While HOLD stalls on id_ready, pc already holds the next sequential address and does not advance again.
- Arithmetic: next PC comes only from pc_add_sum, which is mod 2^32, so 32'hFFFF_FFFC wraps to 0. No internal adder.
- Latency: request accepted at cycle N, response at N+k, id_valid asserted at N+k+1. Minimum of 3 cycles per instruction with zero-wait memory and id_ready held high.
- id_* outputs stay stable while id_valid=1 && id_ready=0.
- Reset mid-operation: any outstanding request is abandoned. Memory must not return a response after reset that this unit treats as valid. Such a response arriving in REQ is ignored.
- imem_rsp_valid seen in REQ or HOLD is ignored. This is a protocol violation; simulation should flag it with an assertion.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory, id_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; id_pc matches; id_pc_plus4=id_pc+4; id_instr equals the returned words.
- Hold id_ready=0 for 5 cycles while bundle pc=0x104 is presented -> id_* stable, no imem request, pc=0x108. Release -> next request at 0x108.
- Redirect to 0x2000 in WAIT, response arrives 2 cycles later -> response discarded, never presented. Next request at 0x2000.
- Redirect to 0x3003 in the same cycle as a REQ handshake -> DROP. Stale response discarded. Next request at 0x3000.
- Redirect to 0x400 during HOLD with id_ready=1 -> bundle not consumed, id_valid=0 next cycle, next request at 0x400.
- RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0. Assert rst=0 in WAIT -> id_valid=0 and pc=RESET_PC the next cycle.
